i2c_shift_engine: RTL and testbench
===================================

Name: i2c_shift_engine

Overview:
- Parametrised command-driven I2C master SDA datapath: executes one bus primitive per accepted command (START, repeated START, STOP, WRITE word, READ word).
- Adds a valid/ready command handshake, arbitration-loss detection, ACK capture, a configurable word width and bit order, and an SDA input synchronizer.
- Sits between the master control FSM (issues commands) and the SCL clock generator, which supplies the drive and sample strobes.

Parameters:
- DATA_W, 8, bits per data word; legal range 1..32.
- MSB_FIRST, 1, 1 = transmit/receive MSB first, 0 = LSB first.
- SYNC_STAGES, 2, flop stages on sda_i; legal range 2..4.

Ports:
- i2c_core_clock_i  input  1  core clock
- reset_bit_n_i  input  1  asynchronous, active-low reset
- cmd_valid_i  input  1  command request
- cmd_ready_o  output  1  engine idle; a command is accepted when valid && ready
- cmd_op_i  input  3  0 NOP, 1 START, 2 WRITE, 3 READ, 4 STOP, 5 RSTART, 6-7 reserved
- tx_data_i  input  DATA_W  word to write; latched at accept
- tx_ack_i  input  1  ACK level driven after a READ (0 = ACK); latched at accept
- scl_fall_i  input  1  one-cycle strobe while SCL is low: the SDA drive point
- scl_rise_i  input  1  one-cycle strobe at the SCL-high sample point; must occur ≥ SYNC_STAGES cycles after the SCL rising edge
- sda_i  input  1  raw SDA pad input
- sda_o  output  1  SDA drive; 1 = release, 0 = pull low
- rx_data_o  output  DATA_W  received word
- rx_ack_o  output  1  ACK sampled after a WRITE
- done_o  output  1  one-cycle pulse when a command completes
- arb_lost_o  output  1  sticky arbitration-loss flag
- bit_cnt_o  output  clog2(DATA_W+1)  current bit slot

Behaviour:
- Reset values: sda_o = 1, cmd_ready_o = 1, done_o = 0, arb_lost_o = 0, rx_ack_o = 1, rx_data_o = 0, bit_cnt_o = 0, synchronizer flops = 1, FSM = IDLE. Reset asserted mid-command releases SDA immediately (asynchronously) and abandons the command.
- States: IDLE, START_W, RS_HI, RS_LO, STOP_LO, STOP_HI, WR_BIT, RD_BIT, DONE.
- cmd_ready_o = 1 only in IDLE. Accepting a command clears arb_lost_o and bit_cnt_o and latches tx_data_i and tx_ack_i.
- START: go to START_W; on the next scl_rise_i, sda_o <= 0, then DONE.
- RSTART: RS_HI; on scl_fall_i, sda_o <= 1, then RS_LO; on the next scl_rise_i, sda_o <= 0, then DONE.
- STOP: STOP_LO; on scl_fall_i, sda_o <= 0, then STOP_HI; on the next scl_rise_i, sda_o <= 1, then DONE.
- WRITE: DATA_W+1 slots, indexed by bit_cnt_o.
  - On scl_fall_i in slot k < DATA_W: drive bit k in the configured order. In slot DATA_W: release SDA.
  - On scl_rise_i in a data slot: if sda_o = 1 and the synchronized SDA = 0, set arb_lost_o = 1, sda_o <= 1, go to DONE. Otherwise bit_cnt_o++.
  - On scl_rise_i in the ACK slot: rx_ack_o <= synchronized SDA, then DONE.
- READ: data slots release SDA. Each scl_rise_i shifts the synchronized SDA into rx_data_o at bit position k, then bit_cnt_o++.
  - On scl_fall_i in the ACK slot: sda_o <= latched tx_ack_i.
  - On scl_rise_i in the ACK slot: go to DONE. SDA is held at the ACK level until the next command's first drive point.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
  - Completion latency: done_o follows the completing strobe by exactly 1 cycle.
  - rx_data_o and rx_ack_o are valid at done_o and hold until the next READ/WRITE accept.
- NOP or a reserved op: accepted, no bus activity, go straight to DONE.
- Strobes arriving in IDLE are ignored. sda_o only changes on a strobe, on reset, or on arbitration loss.
- Simultaneous scl_fall_i and scl_rise_i is illegal: scl_fall_i wins and the bench flags an assertion.
- Widths: bit_cnt_o saturates at DATA_W and wraps to 0 only on accept. Data bit index = MSB_FIRST ? DATA_W-1-k : k.

Decomposition:
- Package i2c_pkg: op-code constants (OP_NOP..OP_RSTART), state encoding, and the function computing the bit-counter width.
- One sub-module, i2c_sda_sync: SYNC_STAGES-deep synchronizer with reset value 1.
- The FSM, shifter and arbitration logic stay in i2c_shift_engine.

Test Plan:
- WRITE 0xA5, slave pulls ACK low → SDA sequence 1,0,1,0,0,1,0,1 then released; rx_ack_o = 0; done_o exactly 1 cycle after the 9th scl_rise_i; arb_lost_o = 0.
- READ, slave drives 0x3C, tx_ack_i = 1 → rx_data_o = 0x3C; ACK slot drives SDA = 1 (NACK); done_o once.
- WRITE 0xFF, external device forces SDA low at the bit-2 sample → arb_lost_o = 1, sda_o = 1 from the next cycle, done_o with bit_cnt_o = 2; no further SDA drive.
- START, RSTART, STOP sequence → SDA falls while SCL high; rises at fall, falls at rise; falls at fall, rises at rise; cmd_ready_o low throughout each command.
- Reset asserted at bit 4 of WRITE 0x00 → sda_o = 1 and cmd_ready_o = 1 asynchronously; a WRITE after reset starts at bit 0.
- DATA_W = 16, MSB_FIRST = 0, WRITE 0x8001 → first bit driven 1, then fourteen 0s, then 1; ACK sampled on the 17th scl_rise_i.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - op-codes, FSM states and sizing helper for the I2C shift engine
package i2c_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_START  = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STOP   = 3'd4;
  localparam logic [2:0] OP_RSTART = 3'd5;

  typedef enum logic [3:0] {
    IDLE,
    START_W,
    RS_HI,
    RS_LO,
    STOP_LO,
    STOP_HI,
    WR_BIT,
    RD_BIT,
    DONE
  } state_t;

  // Bit counter must hold 0..data_w inclusive (data slots plus the ACK slot).
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/i2c_sda_sync.sv
// rtl/i2c_sda_sync.sv - multi-stage SDA pad synchronizer, resets to the released level
module i2c_sda_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/i2c_shift_engine.sv
// rtl/i2c_shift_engine.sv - command-driven I2C master SDA datapath
module i2c_shift_engine
  import i2c_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i2c_core_clock_i,
  input  logic                          reset_bit_n_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [2:0]                    cmd_op_i,
  input  logic [DATA_W-1:0]             tx_data_i,
  input  logic                          tx_ack_i,
  input  logic                          scl_fall_i,
  input  logic                          scl_rise_i,
  input  logic                          sda_i,
  output logic                          sda_o,
  output logic [DATA_W-1:0]             rx_data_o,
  output logic                          rx_ack_o,
  output logic                          done_o,
  output logic                          arb_lost_o,
  output logic [cnt_width(DATA_W)-1:0]  bit_cnt_o
);

  localparam int CW = cnt_width(DATA_W);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] ACK_SLOT = CW'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] tx_word;
  logic              ack_level;
  logic              sda_sync;
  logic [IW-1:0]     bit_idx;

  i2c_sda_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sda_sync (
    .clk     (i2c_core_clock_i),
    .reset_n (reset_bit_n_i),
    .din     (sda_i),
    .dout    (sda_sync)
  );

  // Only meaningful while bit_cnt_o is in a data slot.
  always_comb begin
    bit_idx = '0;
    if (MSB_FIRST) begin
      bit_idx = IW'(DATA_W - 1 - int'(bit_cnt_o));
    end else begin
      bit_idx = IW'(bit_cnt_o);
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      state       <= IDLE;
      sda_o       <= 1'b1;
      cmd_ready_o <= 1'b1;
      done_o      <= 1'b0;
      arb_lost_o  <= 1'b0;
      rx_ack_o    <= 1'b1;
      rx_data_o   <= '0;
      bit_cnt_o   <= '0;
      tx_word     <= '0;
      ack_level   <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            arb_lost_o  <= 1'b0;
            bit_cnt_o   <= '0;
            tx_word     <= tx_data_i;
            ack_level   <= tx_ack_i;
            case (cmd_op_i)
              OP_START:  state <= START_W;
              OP_RSTART: state <= RS_HI;
              OP_STOP:   state <= STOP_LO;
              OP_WRITE:  state <= WR_BIT;
              OP_READ:   state <= RD_BIT;
              default: begin
                state  <= DONE;
                done_o <= 1'b1;
              end
            endcase
          end
        end
        START_W: begin
          if (!scl_fall_i && scl_rise_i) begin
            sda_o  <= 1'b0;
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        RS_HI: begin
          if (scl_fall_i) begin
            sda_o <= 1'b1;
            state <= RS_LO;
          end
        end
        RS_LO: begin
          if (!scl_fall_i && scl_rise_i) begin
            sda_o  <= 1'b0;
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        STOP_LO: begin
          if (scl_fall_i) begin
            sda_o <= 1'b0;
            state <= STOP_HI;
          end
        end
        STOP_HI: begin
          if (!scl_fall_i && scl_rise_i) begin
            sda_o  <= 1'b1;
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        WR_BIT: begin
          if (scl_fall_i) begin
            sda_o <= (bit_cnt_o == ACK_SLOT) ? 1'b1 : tx_word[bit_idx];
          end else if (scl_rise_i) begin
            if (bit_cnt_o == ACK_SLOT) begin
              rx_ack_o <= sda_sync;
              state    <= DONE;
              done_o   <= 1'b1;
            end else if (sda_o && !sda_sync) begin
              // Another master holds the line low while we release it.
              arb_lost_o <= 1'b1;
              sda_o      <= 1'b1;
              state      <= DONE;
              done_o     <= 1'b1;
            end else begin
              bit_cnt_o <= bit_cnt_o + CW'(1);
            end
          end
        end
        RD_BIT: begin
          if (scl_fall_i) begin
            sda_o <= (bit_cnt_o == ACK_SLOT) ? ack_level : 1'b1;
          end else if (scl_rise_i) begin
            if (bit_cnt_o == ACK_SLOT) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              rx_data_o[bit_idx] <= sda_sync;
              bit_cnt_o          <= bit_cnt_o + CW'(1);
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_shift_engine.sv
// tb/tb_i2c_shift_engine.sv - directed self-checking bench for i2c_shift_engine
module tb_i2c_shift_engine;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid8 = 1'b0;
  logic        valid16 = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] tx_data = 16'h0;
  logic        tx_ack = 1'b1;
  logic        scl_fall = 1'b0;
  logic        scl_rise = 1'b0;
  logic        slave_sda = 1'b1;
  bit          sel16 = 1'b0;

  logic        ready8, sda8, rx_ack8, done8, arb8;
  logic [7:0]  rx_data8;
  logic [3:0]  cnt8;
  logic        ready16, sda16, rx_ack16, done16, arb16;
  logic [15:0] rx_data16;
  logic [4:0]  cnt16;

  // Open-drain bus: the line is low if either side pulls it low.
  wire line8  = sda8 & slave_sda;
  wire line16 = sda16 & slave_sda;

  wire        cur_sda   = sel16 ? sda16   : sda8;
  wire        cur_ready = sel16 ? ready16 : ready8;
  wire        cur_done  = sel16 ? done16  : done8;
  wire        cur_arb   = sel16 ? arb16   : arb8;
  wire        cur_rxack = sel16 ? rx_ack16 : rx_ack8;
  wire [4:0]  cur_cnt   = sel16 ? cnt16   : {1'b0, cnt8};

  int n_checks = 0;
  int n_err = 0;
  int dcnt8 = 0;
  int dcnt16 = 0;
  int done_base = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done8) dcnt8++;
    if (done16) dcnt16++;
  end

  always @(posedge clk) begin
    assert (!(scl_fall && scl_rise)) else $error("scl_fall and scl_rise asserted together");
  end

  i2c_shift_engine #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
    .i2c_core_clock_i (clk),
    .reset_bit_n_i    (reset_n),
    .cmd_valid_i      (valid8),
    .cmd_ready_o      (ready8),
    .cmd_op_i         (cmd_op),
    .tx_data_i        (tx_data[7:0]),
    .tx_ack_i         (tx_ack),
    .scl_fall_i       (scl_fall),
    .scl_rise_i       (scl_rise),
    .sda_i            (line8),
    .sda_o            (sda8),
    .rx_data_o        (rx_data8),
    .rx_ack_o         (rx_ack8),
    .done_o           (done8),
    .arb_lost_o       (arb8),
    .bit_cnt_o        (cnt8)
  );

  i2c_shift_engine #(.DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(3)) dut16 (
    .i2c_core_clock_i (clk),
    .reset_bit_n_i    (reset_n),
    .cmd_valid_i      (valid16),
    .cmd_ready_o      (ready16),
    .cmd_op_i         (cmd_op),
    .tx_data_i        (tx_data),
    .tx_ack_i         (tx_ack),
    .scl_fall_i       (scl_fall),
    .scl_rise_i       (scl_rise),
    .sda_i            (line16),
    .sda_o            (sda16),
    .rx_data_o        (rx_data16),
    .rx_ack_o         (rx_ack16),
    .done_o           (done16),
    .arb_lost_o       (arb16),
    .bit_cnt_o        (cnt16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit sel, input logic [2:0] op, input logic [15:0] data, input bit ack);
    sel16   = sel;
    cmd_op  = op;
    tx_data = data;
    tx_ack  = ack;
    done_base = sel ? dcnt16 : dcnt8;
    check("ready_idle", 32'(cur_ready), 32'd1);
    if (sel) valid16 = 1'b1; else valid8 = 1'b1;
    tick();
    valid8  = 1'b0;
    valid16 = 1'b0;
    check("ready_busy", 32'(cur_ready), 32'd0);
    check("arb_clear", 32'(cur_arb), 32'd0);
    check("cnt_clear", 32'(cur_cnt), 32'd0);
  endtask

  task automatic finish_cmd(input string tag);
    tick();
    check({tag, "_done_off"}, 32'(cur_done), 32'd0);
    check({tag, "_ready_back"}, 32'(cur_ready), 32'd1);
    check({tag, "_done_once"}, 32'((sel16 ? dcnt16 : dcnt8) - done_base), 32'd1);
  endtask

  // One character per slot: expected SDA after the drive point, and what the slave drives.
  task automatic run_bits(input string tag, input string exp_sda, input string slave, input bit complete);
    int n;
    n = exp_sda.len();
    for (int k = 0; k < n; k++) begin
      scl_fall = 1'b1;
      tick();
      scl_fall = 1'b0;
      check($sformatf("%s_sda%0d", tag, k), 32'(cur_sda), 32'(exp_sda[k] == "1"));
      slave_sda = (slave[k] == "1");
      repeat (3) tick();
      scl_rise = 1'b1;
      tick();
      scl_rise = 1'b0;
      check($sformatf("%s_done%0d", tag, k), 32'(cur_done), 32'(complete && (k == n - 1)));
    end
    slave_sda = 1'b1;
  endtask

  task automatic prim(input string tag, input logic [2:0] op, input bit exp_fall, input bit exp_rise);
    issue(1'b0, op, 16'h0, 1'b1);
    scl_fall = 1'b1;
    tick();
    scl_fall = 1'b0;
    check({tag, "_sda_fall"}, 32'(cur_sda), 32'(exp_fall));
    check({tag, "_busy"}, 32'(cur_ready), 32'd0);
    repeat (2) tick();
    scl_rise = 1'b1;
    tick();
    scl_rise = 1'b0;
    check({tag, "_sda_rise"}, 32'(cur_sda), 32'(exp_rise));
    check({tag, "_done"}, 32'(cur_done), 32'd1);
    finish_cmd(tag);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_sda", 32'(sda8), 32'd1);
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_arb", 32'(arb8), 32'd0);
    check("rst_rxack", 32'(rx_ack8), 32'd1);
    check("rst_rxdata", 32'(rx_data8), 32'd0);
    check("rst_cnt", 32'(cnt8), 32'd0);
    check("rst_sda16", 32'(sda16), 32'd1);
    reset_n = 1'b1;
    tick();

    issue(1'b0, OP_NOP, 16'h0, 1'b1);
    check("nop_done", 32'(cur_done), 32'd1);
    finish_cmd("nop");

    issue(1'b0, OP_WRITE, 16'h00A5, 1'b1);
    run_bits("wr_a5", "101001011", "111111110", 1'b1);
    check("wr_a5_rxack", 32'(rx_ack8), 32'd0);
    check("wr_a5_arb", 32'(arb8), 32'd0);
    check("wr_a5_cnt_sat", 32'(cnt8), 32'd8);
    finish_cmd("wr_a5");

    issue(1'b0, OP_READ, 16'h0, 1'b1);
    run_bits("rd_3c", "111111111", "001111001", 1'b1);
    check("rd_3c_data", 32'(rx_data8), 32'h3C);
    finish_cmd("rd_3c");
    check("rd_3c_rxack_hold", 32'(rx_ack8), 32'd0);

    issue(1'b0, OP_READ, 16'h0, 1'b0);
    run_bits("rd_81", "111111110", "100000011", 1'b1);
    check("rd_81_data", 32'(rx_data8), 32'h81);
    finish_cmd("rd_81");
    check("rd_81_ack_held", 32'(sda8), 32'd0);

    issue(1'b0, OP_WRITE, 16'h00FF, 1'b1);
    run_bits("arb", "111", "110", 1'b1);
    check("arb_flag", 32'(arb8), 32'd1);
    check("arb_sda", 32'(sda8), 32'd1);
    check("arb_cnt", 32'(cnt8), 32'd2);
    finish_cmd("arb");
    check("arb_sticky", 32'(arb8), 32'd1);

    scl_fall = 1'b1;
    tick();
    scl_fall = 1'b0;
    scl_rise = 1'b1;
    tick();
    scl_rise = 1'b0;
    tick();
    check("idle_strobe_sda", 32'(sda8), 32'd1);
    check("idle_strobe_done", 32'(done8), 32'd0);
    check("idle_strobe_ready", 32'(ready8), 32'd1);

    prim("start", OP_START, 1'b1, 1'b0);
    prim("rstart", OP_RSTART, 1'b1, 1'b0);
    prim("stop", OP_STOP, 1'b0, 1'b1);

    issue(1'b0, OP_WRITE, 16'h0000, 1'b1);
    run_bits("wr_00", "0000", "1111", 1'b0);
    scl_fall = 1'b1;
    tick();
    scl_fall = 1'b0;
    check("wr_00_bit4_sda", 32'(sda8), 32'd0);
    check("wr_00_bit4_cnt", 32'(cnt8), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_sda", 32'(sda8), 32'd1);
    check("async_rst_ready", 32'(ready8), 32'd1);
    #1;
    reset_n = 1'b1;
    tick();

    issue(1'b0, OP_WRITE, 16'h0080, 1'b1);
    run_bits("wr_80", "100000001", "111111110", 1'b1);
    check("wr_80_rxack", 32'(rx_ack8), 32'd0);
    finish_cmd("wr_80");

    issue(1'b1, OP_WRITE, 16'h8001, 1'b1);
    run_bits("w16", "10000000000000011", "11111111111111110", 1'b1);
    check("w16_rxack", 32'(rx_ack16), 32'd0);
    check("w16_cnt_sat", 32'(cnt16), 32'd16);
    finish_cmd("w16");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
